// File: rtl/apb_irq_arbiter_pkg.sv
// Shared constants for the APB interrupt arbiter: register word offsets,
// CTRL/CLAIM bit positions, ID width and FSM state encoding.
package apb_irq_arbiter_pkg;

    localparam int ID_W = 5;

    // Word offsets (bus address bits [7:2])
    localparam logic [5:0] OFF_ENABLE   = 6'h00;
    localparam logic [5:0] OFF_EDGE     = 6'h01;
    localparam logic [5:0] OFF_PENDING  = 6'h02;
    localparam logic [5:0] OFF_CLAIM    = 6'h03;
    localparam logic [5:0] OFF_COMPLETE = 6'h04;
    localparam logic [5:0] OFF_CTRL     = 6'h05;

    localparam int CTRL_GEN_BIT    = 0;
    localparam int CTRL_RR_BIT     = 1;
    localparam int CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } state_t;

endpackage

// File: rtl/apb_irq_arbiter_picker.sv
// Find-first-set over the candidate vector starting at index 'rot' and
// wrapping around. rot = 0 gives plain lowest-index-wins priority.
module irq_rr_picker
    import apb_irq_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 32
) (
    input  logic [NUM_SRC-1:0] cand,
    input  logic [ID_W-1:0]    rot,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [NUM_SRC-1:0] rotated;

    // Rotate so bit 0 is the highest-priority slot, then scan downwards so
    // the last hit (lowest rotated index) is the one that sticks.
    always_comb begin
        rotated = NUM_SRC'({cand, cand} >> rot);
        valid   = 1'b0;
        id      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid = 1'b1;
                id    = ID_W'((int'(rot) + k) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/apb_irq_arbiter.sv
// APB-programmable interrupt arbiter: synchronises sources, latches edge or
// level requests, picks one winner (fixed or round-robin) and runs a
// claim/complete handshake so only one source is in service at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no request presented; waiting for a non-empty candidate set
// ST_PEND | irq_o high, irq_id tracks the current winner until CLAIM
// ST_SERV | a source has been claimed; waiting for matching COMPLETE
module apb_irq_arbiter
    import apb_irq_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               PSEL,
    input  logic [5:0]         PADDR,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service
);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s_d_q, enable_q, edge_q, pending_q, pending_d;
    logic [NUM_SRC-1:0] sync_v, claim_mask, srv_mask, w1c_mask, cand;
    logic               gen_q, rr_q;
    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, srv_id_q, rot, pick_id;
    logic               pick_valid;
    logic               access, wr, rd, mapped;
    logic               claim_fire, complete_wr, complete_ok;

    assign access      = PSEL & PENABLE;
    assign wr          = access & PWRITE;
    assign rd          = access & ~PWRITE;
    assign mapped      = (PADDR <= OFF_CTRL);
    assign claim_fire  = rd & (PADDR == OFF_CLAIM) & (state_q == ST_PEND);
    assign complete_wr = wr & (PADDR == OFF_COMPLETE);
    assign complete_ok = complete_wr & (state_q == ST_SERV) & (PWDATA[ID_W-1:0] == srv_id_q);

    assign sync_v     = sync_q[SYNC_STAGES-1];
    assign claim_mask = claim_fire ? (NUM_SRC'(1) << irq_id) : '0;
    assign srv_mask   = in_service ? (NUM_SRC'(1) << srv_id_q) : '0;
    assign w1c_mask   = (wr && PADDR == OFF_PENDING) ? PWDATA[NUM_SRC-1:0] : '0;
    assign cand       = pending_q & enable_q & ~srv_mask & {NUM_SRC{gen_q}};
    assign rot        = !rr_q ? '0 :
                        (last_grant_q == ID_W'(NUM_SRC - 1)) ? '0 : last_grant_q + 1'b1;

    assign PREADY     = 1'b1;
    assign PSLVERR    = access & (~mapped | (complete_wr & ~complete_ok));
    assign irq_o      = state_q == ST_PEND;

    irq_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .cand  (cand),
        .rot   (rot),
        .valid (pick_valid),
        .id    (pick_id)
    );

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            s_d_q <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            s_d_q <= sync_v;
        end
    end

    // Pending: edge bits set on rise (set beats clear), level bits follow sync
    always_comb begin
        pending_d = (edge_q & ((sync_v & ~s_d_q) | (pending_q & ~(w1c_mask | claim_mask))))
                  | (~edge_q & sync_v);
    end

    // Configuration registers and pending vector
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            enable_q  <= '0;
            edge_q    <= '0;
            gen_q     <= 1'b0;
            rr_q      <= 1'b0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (wr && PADDR == OFF_ENABLE) enable_q <= PWDATA[NUM_SRC-1:0];
            if (wr && PADDR == OFF_EDGE)   edge_q   <= PWDATA[NUM_SRC-1:0];
            if (wr && PADDR == OFF_CTRL) begin
                gen_q <= PWDATA[CTRL_GEN_BIT];
                rr_q  <= PWDATA[CTRL_RR_BIT];
            end
        end
    end

    // Next-state logic for the request/claim/complete handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_PEND;
            ST_PEND: begin
                if (claim_fire)       state_d = ST_SERV;
                else if (!pick_valid) state_d = ST_IDLE;
            end
            ST_SERV: if (complete_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered outputs; winner is re-sampled every cycle
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ST_IDLE;
            irq_id       <= '0;
            in_service   <= 1'b0;
            srv_id_q     <= '0;
            last_grant_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_id     <= (state_d == ST_PEND) ? pick_id : '0;
            in_service <= state_d == ST_SERV;
            if (claim_fire) begin
                srv_id_q     <= irq_id;
                last_grant_q <= irq_id;
            end
        end
    end

    // Read mux; CLAIM only reports a valid id while a request is presented
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                OFF_ENABLE:  PRDATA = 32'(enable_q);
                OFF_EDGE:    PRDATA = 32'(edge_q);
                OFF_PENDING: PRDATA = 32'(pending_q);
                OFF_CLAIM: begin
                    if (state_q == ST_PEND) begin
                        PRDATA[CLAIM_VALID_BIT] = 1'b1;
                        PRDATA[ID_W-1:0]        = irq_id;
                    end
                end
                OFF_CTRL: begin
                    PRDATA[CTRL_GEN_BIT] = gen_q;
                    PRDATA[CTRL_RR_BIT]  = rr_q;
                end
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_arbiter.sv
// Scoreboard bench for apb_irq_arbiter: APB transfers and interrupt
// presentations push expectations into queues; monitors pop and compare.
module tb_apb_irq_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [5:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] irq_src;
    logic        irq_o;
    logic [4:0]  irq_id;
    logic        in_service;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
        string       name;
    } apb_exp_t;

    apb_exp_t   apb_q[$];
    logic [4:0] irq_q[$];

    apb_irq_arbiter #(.NUM_SRC(32), .SYNC_STAGES(2)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .PSEL       (PSEL),
        .PADDR      (PADDR),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .irq_src    (irq_src),
        .irq_o      (irq_o),
        .irq_id     (irq_id),
        .in_service (in_service)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // APB monitor: every completed access pops one expectation
    apb_exp_t e;
    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE) begin
            if (apb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL apb_unexpected: access at offset 0x%02h with empty queue", PADDR);
            end else begin
                e = apb_q.pop_front();
                check({e.name, "_err"}, 32'(PSLVERR), 32'(e.err));
                if (e.chk_rdata) check({e.name, "_data"}, PRDATA, e.rdata);
            end
        end
    end

    // IRQ monitor: every rising irq_o pops one expected id
    logic irq_prev = 1'b0;
    always @(negedge PCLK) begin
        if (irq_o && !irq_prev) begin
            if (irq_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL irq_unexpected: got id %0d expected no request", irq_id);
            end else begin
                check("irq_id", 32'(irq_id), 32'(irq_q.pop_front()));
            end
        end
        irq_prev = irq_o;
    end

    task automatic apb(input logic w, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input string name);
        apb_exp_t x;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = w; PADDR = addr[7:2]; PWDATA = wdata; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        x.rdata = exp_rdata; x.err = exp_err; x.chk_rdata = !w; x.name = name;
        apb_q.push_back(x);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] d, input logic err, input string name);
        apb(1'b1, addr, d, 32'h0, err, name);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input logic err, input string name);
        apb(1'b0, addr, 32'h0, exp, err, name);
    endtask

    task automatic wait_irq(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                @(negedge PCLK);
                seen = irq_o;
            end
        end
        check(name, 32'(seen), 32'h1);
    endtask

    task automatic pulse(input logic [31:0] bits);
        @(posedge PCLK); #1; irq_src = bits;
        @(posedge PCLK); #1; irq_src = 32'h0;
    endtask

    logic [4:0] rr_ids [4] = '{5'd2, 5'd5, 5'd7, 5'd2};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; irq_src = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_irq_o", 32'(irq_o), 32'h0);
        check("rst_irq_id", 32'(irq_id), 32'h0);
        check("rst_in_service", 32'(in_service), 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        @(posedge PCLK); #1; PRESETn = 1'b1;

        // Fixed priority, edge sources 3 and 9 together
        wr(8'h14, 32'h1, 1'b0, "w_ctrl");
        wr(8'h00, 32'hFFFF_FFFF, 1'b0, "w_enable");
        wr(8'h04, 32'hFFFF_FFFF, 1'b0, "w_edge");
        irq_q.push_back(5'd3);
        @(posedge PCLK); #1; irq_src = 32'h208;
        for (int k = 1; k <= 4; k++) begin
            @(posedge PCLK); #1;
            if (k == 1) irq_src = 32'h0;
            if (k == 3) check("lat_early", 32'(irq_o), 32'h0);
            if (k == 4) check("lat_on_time", 32'(irq_o), 32'h1);
        end
        rd(8'h08, 32'h208, 1'b0, "pend_both");
        rd(8'h0C, 32'h8000_0003, 1'b0, "claim3");
        check("insvc_after_claim", 32'(in_service), 32'h1);
        check("irq_low_in_serv", 32'(irq_o), 32'h0);
        rd(8'h08, 32'h200, 1'b0, "pend_after_claim");
        rd(8'h0C, 32'h0, 1'b0, "claim_in_serv");
        wr(8'h10, 32'd6, 1'b1, "complete_wrong");
        check("insvc_after_bad", 32'(in_service), 32'h1);
        rd(8'h18, 32'h0, 1'b1, "unmapped");
        rd(8'h10, 32'h0, 1'b0, "read_complete");
        irq_q.push_back(5'd9);
        wr(8'h10, 32'd3, 1'b0, "complete3");
        wait_irq("irq9_seen");
        rd(8'h0C, 32'h8000_0009, 1'b0, "claim9");
        wr(8'h10, 32'd9, 1'b0, "complete9");
        check("insvc_after_done", 32'(in_service), 32'h0);
        rd(8'h0C, 32'h0, 1'b0, "claim_idle");

        // W1C removes an edge request before it is claimed
        irq_q.push_back(5'd1);
        pulse(32'h2);
        wait_irq("irq1_seen");
        wr(8'h08, 32'h2, 1'b0, "w1c1");
        repeat (2) @(posedge PCLK); #1;
        check("irq_after_w1c", 32'(irq_o), 32'h0);
        rd(8'h08, 32'h0, 1'b0, "pend_after_w1c");

        // New edge on source 3 lands on the same edge as its claim
        irq_q.push_back(5'd3);
        pulse(32'h8);
        wait_irq("irq3b_seen");
        repeat (3) @(posedge PCLK);
        @(posedge PCLK); #1; irq_src = 32'h8;
        rd(8'h0C, 32'h8000_0003, 1'b0, "claim_sim");
        irq_src = 32'h0;
        rd(8'h08, 32'h8, 1'b0, "pend_set_wins");
        check("masked_in_serv", 32'(irq_o), 32'h0);
        irq_q.push_back(5'd3);
        wr(8'h10, 32'd3, 1'b0, "complete3b");
        wait_irq("irq3_rereq");
        rd(8'h0C, 32'h8000_0003, 1'b0, "claim3c");
        wr(8'h10, 32'd3, 1'b0, "complete3c");

        // Level source 4 drops before claim
        wr(8'h04, 32'h0, 1'b0, "w_edge_level");
        irq_q.push_back(5'd4);
        irq_src = 32'h10;
        wait_irq("irq4_level");
        irq_src = 32'h0;
        repeat (6) @(posedge PCLK); #1;
        check("irq_level_drop", 32'(irq_o), 32'h0);
        rd(8'h0C, 32'h0, 1'b0, "claim_after_drop");

        // Edge source 4, one-cycle pulse, pending persists
        wr(8'h04, 32'h10, 1'b0, "w_edge4");
        irq_q.push_back(5'd4);
        pulse(32'h10);
        repeat (8) @(posedge PCLK); #1;
        check("edge_persist", 32'(irq_o), 32'h1);
        rd(8'h08, 32'h10, 1'b0, "pend4");
        rd(8'h0C, 32'h8000_0004, 1'b0, "claim4");
        rd(8'h08, 32'h0, 1'b0, "pend4_cleared");
        wr(8'h10, 32'd4, 1'b0, "complete4");
        check("insvc_after4", 32'(in_service), 32'h0);

        // Reset while in service
        irq_q.push_back(5'd4);
        pulse(32'h10);
        wait_irq("irq4_rst");
        rd(8'h0C, 32'h8000_0004, 1'b0, "claim4_rst");
        check("insvc_before_rst", 32'(in_service), 32'h1);
        @(posedge PCLK); #1; PRESETn = 1'b0;
        #1;
        check("rst_mid_irq", 32'(irq_o), 32'h0);
        check("rst_mid_insvc", 32'(in_service), 32'h0);
        repeat (2) @(posedge PCLK); #1; PRESETn = 1'b1;
        rd(8'h00, 32'h0, 1'b0, "rst_enable");
        rd(8'h04, 32'h0, 1'b0, "rst_edge");
        rd(8'h08, 32'h0, 1'b0, "rst_pending");
        rd(8'h14, 32'h0, 1'b0, "rst_ctrl");

        // Round-robin over level sources 2, 5, 7
        wr(8'h00, 32'hFFFF_FFFF, 1'b0, "w_enable_rr");
        wr(8'h14, 32'h3, 1'b0, "w_ctrl_rr");
        rd(8'h14, 32'h3, 1'b0, "ctrl_rr");
        irq_q.push_back(rr_ids[0]);
        irq_src = 32'hA4;
        for (int i = 0; i < 4; i++) begin
            wait_irq("irq_rr_seen");
            rd(8'h0C, 32'h8000_0000 | 32'(rr_ids[i]), 1'b0, "claim_rr");
            if (i < 3) begin
                irq_q.push_back(rr_ids[i+1]);
            end else begin
                irq_src = 32'h0;
                repeat (5) @(posedge PCLK);
            end
            wr(8'h10, 32'(rr_ids[i]), 1'b0, "complete_rr");
        end

        repeat (6) @(posedge PCLK);
        check("apb_q_drained", 32'(apb_q.size()), 32'h0);
        check("irq_q_drained", 32'(irq_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_irq_arbiter.md
Name: apb_irq_arbiter

Overview:
APB-programmable interrupt arbiter for the 32-bit peripheral interrupt vector (UART, timer, per-pin and combined GPIO lines) produced by the APB subsystem. It synchronises the sources and latches edge- or level-type requests. It picks one winner by fixed or round-robin priority and presents one request/ID pair to the core. A claim/complete handshake over APB allows only one source in service at a time.

Parameters:
NUM_SRC, 32, number of interrupt sources (1..32); source i is bit i everywhere.
SYNC_STAGES, 2, synchroniser flops per source (1..3).

Ports:
PCLK  input  1  APB clock; all state is clocked on its rising edge.
PRESETn  input  1  reset, asynchronous assert, active-low.
PSEL  input  1  APB select.
PADDR  input  6  word offset, bus address bits [7:2].
PENABLE  input  1  APB access phase.
PWRITE  input  1  1 = write.
PWDATA  input  32  write data.
PRDATA  output  32  read data, combinational from registers.
PREADY  output  1  tied 1; no wait states.
PSLVERR  output  1  error response.
irq_src  input  NUM_SRC  raw interrupt sources, may be asynchronous.
irq_o  output  1  registered request to the core.
irq_id  output  5  registered ID of the current winner.
in_service  output  1  high while a claimed source awaits completion.

Behaviour:
- Reset: all outputs 0 (PREADY=1). All registers, synchronisers, pending, last-grant and state are 0; state is IDLE.
- Register map, transfer completes on PSEL&PENABLE:
  - 0x00 ENABLE RW: per-source mask.
  - 0x04 EDGE RW: 1 = rising-edge source, 0 = level source.
  - 0x08 PENDING RO/W1C: W1C clears edge bits only; level bits ignore writes.
  - 0x0C CLAIM RO: reads {valid[31], 26'b0, id[4:0]}.
  - 0x10 COMPLETE WO: PWDATA[4:0] = id.
  - 0x14 CTRL RW: bit0 global enable GEN, bit1 RR mode (0 = fixed).
- Unmapped offsets: PRDATA=0, PSLVERR=1 in the access phase, no side effects. Reads of 0x10 return 0 with no error.
- Synchroniser: SYNC_STAGES flops, then one history flop s_d.
- Edge source: pending bit sets when sync=1 and s_d=0.
- Level source: pending bit equals sync level.
- Request latency: pending sets SYNC_STAGES+1 edges after irq_src is first sampled high. irq_o/irq_id update one edge later.
- Candidate set: pending & ENABLE & ~in-service source, qualified by GEN.
- Fixed mode: lowest index wins.
- RR mode: first candidate strictly above last-granted index, wrapping to 0. Last-grant updates only on a successful claim.
- Arbitration is re-evaluated every cycle while in PEND, so irq_id may change before the claim.
- FSM states IDLE, PEND, SERV:
  - IDLE -> PEND when candidate set ≠ 0; irq_o=1 next cycle.
  - PEND -> IDLE when the candidates vanish (disable, level drop, W1C); irq_o and irq_id drop to 0.
  - PEND -> SERV on a CLAIM read. PRDATA returns {1, irq_id} of that cycle. Edge pending bit of that id clears, in_service=1, irq_o=0.
  - SERV -> IDLE on a COMPLETE write whose id equals the serviced id. in_service=0, and arbitration resumes the next cycle.
- CLAIM read in IDLE or SERV: returns 0, no state change, no error.
- COMPLETE with wrong id or outside SERV: ignored, PSLVERR=1.
- A new edge on the serviced source while in SERV re-sets pending; it is masked until complete.
- A new edge on the same cycle as a claim or W1C of that bit: set wins, pending stays 1.
- A level source still high after complete is re-requested.
- Clearing ENABLE or GEN during SERV does not abort service; complete is still required.
- PRESETn low mid-operation: immediate return to the reset values; an un-completed claim is discarded.

Decomposition:
- Shared package: register offset constants (ENABLE..CTRL), CTRL bit positions, CLAIM valid bit position, FSM state encoding, ID width 5.
- Sub-module irq_rr_picker: combinational find-first-set on candidates rotated by last-grant+1, returning a valid flag and id. Used with rotation 0 for fixed mode.

Test Plan:
- Fixed priority: ENABLE=0xFFFF_FFFF, GEN=1, pulse sources 3 and 9 together (edge mode) -> irq_o high SYNC_STAGES+2 edges later with irq_id=3. CLAIM reads 0x8000_0003; complete 3 -> irq_id=9 next.
- Round-robin: RR=1, level sources 2, 5, 7 held high, claim/complete repeated -> ids 2, 5, 7, 2.
- Level vs edge: level source 4 dropped before claim -> irq_o falls, state IDLE, CLAIM reads 0x0. Edge source 4 pulsed for 1 cycle -> pending persists until claimed.
- Error/protocol: COMPLETE id=6 while serving 3 -> PSLVERR=1, in_service stays 1. Read offset 0x18 -> PRDATA=0, PSLVERR=1.
- Simultaneous: new edge on source 3 in the same cycle as its claim -> PENDING[3]=1 after claim; re-requested after complete.
- Reset mid-service: PRESETn low while in SERV -> irq_o=0, in_service=0, all registers read 0 after release.
